// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler: owner states,
// grant bit positions, the all-dark blank mask and a digit field helper.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TIME  = 2'd1,
        ST_MSG   = 2'd2,
        ST_ALERT = 2'd3
    } state_e;

    localparam int GNT_TIME  = 0;
    localparam int GNT_MSG   = 1;
    localparam int GNT_ALERT = 2;

    localparam logic [3:0] BLANK_ALL = 4'b1111;

    // Digit 0 is the rightmost nibble of a 4-digit word.
    function automatic logic [3:0] digit_at(input logic [15:0] word, input logic [1:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/disp_sched_if.sv
// Requester-side inputs and scanner-side outputs of the display scheduler.
// The control FSM / bench is the master, the scheduler is the slave.
interface disp_sched_if;
    import disp_sched_pkg::*;

    logic        req_alert;
    logic [15:0] alert_code;
    logic        req_msg;
    logic [15:0] msg_code;
    logic        req_time;
    logic [15:0] time_digits;

    logic [3:0]  l0;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic [3:0]  l3;
    logic        letter_mode;
    logic [3:0]  blank_mask;
    logic [2:0]  grant;
    logic        msg_busy;

    modport master (
        output req_alert, alert_code, req_msg, msg_code, req_time, time_digits,
        input  l0, l1, l2, l3, letter_mode, blank_mask, grant, msg_busy
    );

    modport slave (
        input  req_alert, alert_code, req_msg, msg_code, req_time, time_digits,
        output l0, l1, l2, l3, letter_mode, blank_mask, grant, msg_busy
    );

endinterface

// File: rtl/disp_sched_tick_gen.sv
// Cycle divider: counts enabled cycles and emits a one-cycle pulse on the
// DIV-th one. A synchronous clear takes priority and suppresses the pulse.
module sched_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: shares the 4-digit scanner between alert, message and
// run-time requesters by fixed priority, with blinking and digit blanking.
module disp_sched #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned BLINK_DIV = 50000000,
    parameter int unsigned MSG_HOLD  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    disp_sched_if.slave  sched_if
);
    import disp_sched_pkg::*;

    localparam int HOLD_W = (MSG_HOLD > 1) ? $clog2(MSG_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MSG_HOLD - 1);

    state_e             state_q, state_d;
    logic [15:0]        msg_code_q, msg_code_d;
    logic               msg_busy_q, msg_busy_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [15:0]        digits_q, digits_d;
    logic               letter_q, letter_d;
    logic [3:0]         blank_q, blank_d;
    logic [2:0]         grant_q, grant_d;

    logic               hold_tick, hold_expire, blink_tick, blink_run;
    logic [3:0]         t3, t2;

    // Hold cycles advance only on cycles that do not hand the display to ALERT.
    sched_tick_gen #(.DIV(TICK_DIV)) u_hold_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sched_if.req_msg),
        .en_i   (msg_busy_q && !sched_if.req_alert),
        .tick_o (hold_tick)
    );

    sched_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!blink_run),
        .en_i   (1'b1),
        .tick_o (blink_tick)
    );

    assign hold_expire = hold_tick && (hold_cnt_q == HOLD_LAST);
    assign msg_code_d  = sched_if.req_msg ? sched_if.msg_code : msg_code_q;
    assign blink_run   = (state_q == ST_ALERT) && (state_d == ST_ALERT);
    assign t3          = digit_at(sched_if.time_digits, 2'd3);
    assign t2          = digit_at(sched_if.time_digits, 2'd2);

    always_comb begin
        msg_busy_d = msg_busy_q;
        hold_cnt_d = hold_cnt_q;
        if (sched_if.req_msg) begin
            msg_busy_d = 1'b1;
            hold_cnt_d = '0;
        end else if (hold_expire) begin
            msg_busy_d = 1'b0;
            hold_cnt_d = '0;
        end else if (hold_tick) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    always_comb begin
        if (sched_if.req_alert) begin
            state_d = ST_ALERT;
        end else if (msg_busy_d) begin
            state_d = ST_MSG;
        end else if (sched_if.req_time) begin
            state_d = ST_TIME;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Outputs are computed for the state being entered so they land with it.
    always_comb begin
        digits_d    = '0;
        letter_d    = 1'b0;
        blank_d     = BLANK_ALL;
        grant_d     = '0;
        blink_off_d = 1'b0;
        case (state_d)
            ST_ALERT: begin
                digits_d           = sched_if.alert_code;
                letter_d           = 1'b1;
                blink_off_d        = blink_run && (blink_tick ? !blink_off_q : blink_off_q);
                blank_d            = blink_off_d ? BLANK_ALL : 4'b0000;
                grant_d[GNT_ALERT] = 1'b1;
            end
            ST_MSG: begin
                digits_d         = msg_code_d;
                letter_d         = 1'b1;
                blank_d          = 4'b0000;
                grant_d[GNT_MSG] = 1'b1;
            end
            ST_TIME: begin
                digits_d = sched_if.time_digits;
                for (int i = 0; i < 4; i++) begin
                    blank_d[i] = digit_at(sched_if.time_digits, 2'(i)) > 4'd9;
                end
                if (t3 == 4'd0) begin
                    blank_d[3] = 1'b1;
                    if (t2 == 4'd0) begin
                        blank_d[2] = 1'b1;
                    end
                end
                grant_d[GNT_TIME] = 1'b1;
            end
            default: begin
                digits_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            msg_code_q  <= '0;
            msg_busy_q  <= 1'b0;
            hold_cnt_q  <= '0;
            blink_off_q <= 1'b0;
            digits_q    <= '0;
            letter_q    <= 1'b0;
            blank_q     <= BLANK_ALL;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            msg_code_q  <= msg_code_d;
            msg_busy_q  <= msg_busy_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_off_q <= blink_off_d;
            digits_q    <= digits_d;
            letter_q    <= letter_d;
            blank_q     <= blank_d;
            grant_q     <= grant_d;
        end
    end

    assign sched_if.l0          = digit_at(digits_q, 2'd0);
    assign sched_if.l1          = digit_at(digits_q, 2'd1);
    assign sched_if.l2          = digit_at(digits_q, 2'd2);
    assign sched_if.l3          = digit_at(digits_q, 2'd3);
    assign sched_if.letter_mode = letter_q;
    assign sched_if.blank_mask  = blank_q;
    assign sched_if.grant       = grant_q;
    assign sched_if.msg_busy    = msg_busy_q;

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: a behavioural model pushes expected
// outputs per driven cycle and they are compared after the following edge.
module tb_disp_sched;
    import disp_sched_pkg::*;

    localparam int TICK  = 10;
    localparam int BLINK = 4;
    localparam int HOLD  = 2;

    typedef struct packed {
        logic [15:0] l;
        logic        letter;
        logic [3:0]  blank;
        logic [2:0]  grant;
        logic        busy;
    } exp_t;

    logic clk;
    logic rst_n;
    disp_sched_if bus ();

    disp_sched #(.TICK_DIV(TICK), .BLINK_DIV(BLINK), .MSG_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        expQ[$];
    int          errCount = 0;
    int          checkCount = 0;
    int          msgSeen = 0;
    int          alertSeen = 0;
    logic [15:0] alertPat = '0;

    state_e      mState;
    logic        mBusy;
    int          mLeft;
    logic [15:0] mCode;
    int          mBcnt;
    logic        mOff;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mState = ST_IDLE;
        mBusy  = 1'b0;
        mLeft  = 0;
        mCode  = '0;
        mBcnt  = 0;
        mOff   = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_grant"}, 16'(bus.grant), 16'h0);
        checkOutput({tag, "_blank"}, 16'(bus.blank_mask), 16'hF);
        checkOutput({tag, "_letter"}, 16'(bus.letter_mode), 16'h0);
        checkOutput({tag, "_digits"}, {bus.l3, bus.l2, bus.l1, bus.l0}, 16'h0);
        checkOutput({tag, "_busy"}, 16'(bus.msg_busy), 16'h0);
    endtask

    task automatic checkDue();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 16'h1, 16'h0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("grant", 16'(bus.grant), 16'(e.grant));
        checkOutput("blank", 16'(bus.blank_mask), 16'(e.blank));
        checkOutput("letter", 16'(bus.letter_mode), 16'(e.letter));
        checkOutput("digits", {bus.l3, bus.l2, bus.l1, bus.l0}, e.l);
        checkOutput("busy", 16'(bus.msg_busy), 16'(e.busy));
        if (bus.grant === 3'b010) msgSeen++;
        if (bus.grant === 3'b100) begin
            alertSeen++;
            alertPat = {alertPat[14:0], bus.blank_mask === 4'hF};
        end
    endtask

    // Drives one cycle of requests, predicts the outputs, then checks after the edge.
    task automatic applyStimulus(input logic ra, input logic [15:0] ac, input logic rm,
                                 input logic [15:0] mc, input logic rt, input logic [15:0] td);
        exp_t       e;
        state_e     prev;
        logic [3:0] d;
        bus.req_alert   = ra;
        bus.alert_code  = ac;
        bus.req_msg     = rm;
        bus.msg_code    = mc;
        bus.req_time    = rt;
        bus.time_digits = td;

        prev = mState;
        if (rm) begin
            mCode = mc;
            mBusy = 1'b1;
            mLeft = HOLD * TICK;
        end else if (mBusy && !ra) begin
            mLeft--;
            if (mLeft == 0) mBusy = 1'b0;
        end
        if (ra)         mState = ST_ALERT;
        else if (mBusy) mState = ST_MSG;
        else if (rt)    mState = ST_TIME;
        else            mState = ST_IDLE;
        if (mState == ST_ALERT && prev == ST_ALERT) begin
            mBcnt++;
            if (mBcnt == BLINK) begin
                mOff  = ~mOff;
                mBcnt = 0;
            end
        end else begin
            mBcnt = 0;
            mOff  = 1'b0;
        end

        e.l = '0; e.letter = 1'b0; e.blank = 4'hF; e.grant = 3'b000; e.busy = mBusy;
        case (mState)
            ST_ALERT: begin
                e.l = ac; e.letter = 1'b1; e.blank = mOff ? 4'hF : 4'h0; e.grant = 3'b100;
            end
            ST_MSG: begin
                e.l = mCode; e.letter = 1'b1; e.blank = 4'h0; e.grant = 3'b010;
            end
            ST_TIME: begin
                e.l = td; e.grant = 3'b001;
                for (int i = 0; i < 4; i++) begin
                    d = td[4*i +: 4];
                    e.blank[i] = (d > 4'd9);
                end
                if (td[15:12] == 4'd0) e.blank[3] = 1'b1;
                if (td[15:12] == 4'd0 && td[11:8] == 4'd0) e.blank[2] = 1'b1;
            end
            default: ;
        endcase
        expQ.push_back(e);

        @(posedge clk);
        #1;
        checkDue();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.req_alert = 1'b0; bus.alert_code = '0; bus.req_msg = 1'b0;
        bus.msg_code = '0; bus.req_time = 1'b0; bus.time_digits = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        #3 rst_n = 1'b1;

        $display("[TB] idle after reset");
        repeat (3) applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0);

        $display("[TB] run time display");
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h0045);
        checkOutput("time0045_blank", 16'(bus.blank_mask), 16'h000C);
        checkOutput("time0045_l1l0", {8'h00, bus.l1, bus.l0}, 16'h0045);
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h1205);
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h1205);
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h00A7);
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h0B00);

        $display("[TB] message hold");
        msgSeen = 0;
        applyStimulus(0, 16'h0, 1, 16'hA3C1, 1, 16'h1205);
        repeat (25) applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h1205);
        checkOutput("msg_hold_cycles", 16'(msgSeen), 16'd20);

        $display("[TB] message restart");
        msgSeen = 0;
        applyStimulus(0, 16'h0, 1, 16'h2222, 1, 16'h0031);
        repeat (14) applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h0031);
        applyStimulus(0, 16'h0, 1, 16'h1111, 1, 16'h0031);
        repeat (30) applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h0031);
        checkOutput("msg_restart_cycles", 16'(msgSeen), 16'd35);

        $display("[TB] alert preempts message");
        msgSeen = 0; alertSeen = 0; alertPat = '0;
        applyStimulus(0, 16'h0, 1, 16'h5A5A, 0, 16'h0);
        repeat (4) applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0);
        repeat (12) applyStimulus(1, 16'hEEEE, 0, 16'h0, 0, 16'h0);
        repeat (25) applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0);
        checkOutput("msg_around_alert", 16'(msgSeen), 16'd20);
        checkOutput("alert_cycles", 16'(alertSeen), 16'd12);
        checkOutput("alert_blink_pattern", alertPat, 16'h00F0);

        $display("[TB] random traffic");
        for (int n = 0; n < 80; n++) begin
            applyStimulus($urandom_range(0, 5) == 0, 16'($urandom),
                          $urandom_range(0, 19) == 0, 16'($urandom),
                          1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("[TB] asynchronous reset during alert");
        repeat (6) applyStimulus(1, 16'hE1E2, 0, 16'h0, 1, 16'h0042);
        #3 rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        modelReset();
        bus.req_alert = 1'b0;
        bus.req_time  = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0);
        checkOutput("grant_after_reset", 16'(bus.grant), 16'h0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
